// File: rtl/udp_tx_buf_pkg.sv
// Shared definitions for the udp_tx_buf transmit client: FSM encodings,
// PSPEPS length width and the default pad length.
package udp_tx_buf_pkg;

  localparam int TX_LEN_W    = 11;
  localparam int DEF_MIN_LEN = 18;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_REQ   = 3'd2,
    ST_SEND  = 3'd3,
    ST_CLOSE = 3'd4
  } tx_state_e;

endpackage

// File: rtl/udp_tx_buf_ram.sv
// Single-clock simple dual-port packet buffer: one write port, one
// registered read port with a one-cycle read latency.
module udp_tx_buf_ram #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array has no reset so it maps onto block RAM; only the read
  // register is reset, which is what makes tx_data clear asynchronously.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/udp_tx_buf.sv
// PSPEPS Tx client: buffers one packet from a local producer, then streams it
// under tx_req/tx_ack/tx_warn. Define UDP_TX_BUF_PAD_EN to zero-pad to MIN_LEN.
module udp_tx_buf
  import udp_tx_buf_pkg::*;
#(
  parameter int AW = 11
`ifdef UDP_TX_BUF_PAD_EN
  , parameter int MIN_LEN = DEF_MIN_LEN
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_strobe,
  input  logic [7:0]          wr_data,
  input  logic                wr_commit,
  output logic                busy,
  output logic                overflow,
  output logic                tx_req,
  output logic [TX_LEN_W-1:0] tx_len,
  input  logic                tx_ack,
  input  logic                tx_warn,
  output logic [7:0]          tx_data
);

  // Highest storable byte count; one slot is left unused so the count fits AW bits.
  localparam logic [TX_LEN_W-1:0] MAX_LEN = TX_LEN_W'((1 << AW) - 1);
  localparam logic [TX_LEN_W-1:0] ONE     = TX_LEN_W'(1);

  tx_state_e           state_q, state_d;
  logic [TX_LEN_W-1:0] cnt_q;
  logic [TX_LEN_W-1:0] rptr_q;
  logic [TX_LEN_W-1:0] len_now;
  logic                byte_acc, byte_drop, commit_go;
  logic                rd_go, last_rd, close_done;
  logic [7:0]          ram_rdata;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign len_now = cnt_q + TX_LEN_W'(byte_acc);

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    byte_acc   = 1'b0;
    byte_drop  = 1'b0;
    commit_go  = 1'b0;
    rd_go      = 1'b0;
    last_rd    = 1'b0;
    close_done = 1'b0;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (wr_strobe) begin
          if (cnt_q == MAX_LEN) byte_drop = 1'b1;
          else                  byte_acc  = 1'b1;
        end
        // The coincident strobe is already counted in len_now.
        if (wr_commit && (len_now != '0)) begin
          commit_go = 1'b1;
          state_d   = ST_REQ;
        end else if (byte_acc) begin
          state_d = ST_FILL;
        end
      end
      ST_REQ, ST_SEND: begin
        if (state_q == ST_REQ && tx_ack) state_d = ST_SEND;
        // An early tx_warn in REQ is a host error but is serviced anyway.
        if (tx_warn) begin
          rd_go = 1'b1;
          if (rptr_q == tx_len - ONE) begin
            last_rd = 1'b1;
            state_d = ST_CLOSE;
          end
        end
      end
      ST_CLOSE: begin
        if (!tx_ack) begin
          close_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      rptr_q   <= '0;
      tx_len   <= '0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (byte_acc) cnt_q <= cnt_q + ONE;
      if (commit_go) begin
`ifdef UDP_TX_BUF_PAD_EN
        tx_len <= (len_now < TX_LEN_W'(MIN_LEN)) ? TX_LEN_W'(MIN_LEN) : len_now;
`else
        tx_len <= len_now;
`endif
        tx_req   <= 1'b1;
        busy     <= 1'b1;
        overflow <= 1'b0;
      end else if (byte_drop) begin
        overflow <= 1'b1;
      end
      if (rd_go)   rptr_q <= rptr_q + ONE;
      if (last_rd) tx_req <= 1'b0;
      if (close_done) begin
        cnt_q  <= '0;
        rptr_q <= '0;
        busy   <= 1'b0;
      end
    end
  end

  udp_tx_buf_ram #(.AW(AW), .DW(8)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (byte_acc),
    .waddr (cnt_q[AW-1:0]),
    .wdata (wr_data),
    .re    (rd_go),
    .raddr (rptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

`ifdef UDP_TX_BUF_PAD_EN
  // cnt_q still holds the stored length while busy; reads past it are padding.
  logic pad_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pad_q <= 1'b0;
    else if (rd_go) pad_q <= (rptr_q >= cnt_q);
  end
  assign tx_data = pad_q ? 8'h00 : ram_rdata;
`else
  assign tx_data = ram_rdata;
`endif

endmodule

// File: tb/tb_udp_tx_buf.sv
// Scoreboard bench for udp_tx_buf (AW=4): stimulus queues expected lengths and
// bytes, a negedge monitor compares them as the DUT presents them.
module tb_udp_tx_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_strobe, wr_commit, tx_ack, tx_warn;
  logic [7:0]  wr_data;
  logic        busy, overflow, tx_req;
  logic [10:0] tx_len;
  logic [7:0]  tx_data;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          stored_n = 0;
  logic [7:0]  exp_q[$];
  logic [10:0] len_q[$];
  logic        warn_seen = 1'b0;
  logic        req_prev  = 1'b0;

  always #5 clk = ~clk;

  udp_tx_buf #(.AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_strobe (wr_strobe),
    .wr_data   (wr_data),
    .wr_commit (wr_commit),
    .busy      (busy),
    .overflow  (overflow),
    .tx_req    (tx_req),
    .tx_len    (tx_len),
    .tx_ack    (tx_ack),
    .tx_warn   (tx_warn),
    .tx_data   (tx_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: tx_len on each tx_req rise, tx_data the cycle after each tx_warn.
  always @(posedge clk) warn_seen <= tx_warn;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_req && !req_prev) begin
        if (len_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_len: unexpected request, got %0d", tx_len);
        end else begin
          check("tx_len", 32'(tx_len), 32'(len_q.pop_front()));
        end
      end
      if (warn_seen) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_data: unexpected byte %0h", tx_data);
        end else begin
          check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
    end
    req_prev = tx_req;
  end

  task automatic write_byte(input logic [7:0] b, input bit stored);
    wr_strobe = 1'b1;
    wr_data   = b;
    if (stored) begin
      exp_q.push_back(b);
      stored_n++;
    end
    tick();
    wr_strobe = 1'b0;
  endtask

  // Also used with wr_strobe already raised by the caller for a coincident byte.
  task automatic commit(output int exp_len);
`ifdef UDP_TX_BUF_PAD_EN
    exp_len = (stored_n < 18) ? 18 : stored_n;
`else
    exp_len = stored_n;
`endif
    for (int i = stored_n; i < exp_len; i++) exp_q.push_back(8'h00);
    len_q.push_back(11'(exp_len));
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
    wr_strobe = 1'b0;
    stored_n  = 0;
    check("req_after_commit", 32'(tx_req), 32'd1);
    check("busy_after_commit", 32'(busy), 32'd1);
  endtask

  task automatic host_send(input int n);
    int waited = 0;
    while (!tx_req && waited < 10) begin
      tick();
      waited++;
    end
    check("req_seen", 32'(tx_req), 32'd1);
    if (tx_req) begin
      tx_ack = 1'b1;
      tick();
      for (int i = 0; i < n; i++) begin
        tx_warn = 1'b1;
        tick();
        tx_warn = 1'b0;
        check("req_during_send", 32'(tx_req), (i == n - 1) ? 32'd0 : 32'd1);
        tick();
      end
      check("busy_in_close", 32'(busy), 32'd1);
      tx_ack = 1'b0;
      tick();
      check("busy_after_close", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int len;
    rst = 1'b1; wr_strobe = 1'b0; wr_commit = 1'b0; wr_data = 8'h00;
    tx_ack = 1'b0; tx_warn = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_tx_req", 32'(tx_req), 32'd0);
    check("rst_tx_len", 32'(tx_len), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Basic packet 01..08.
    for (int i = 1; i <= 8; i++) write_byte(8'(i), 1'b1);
    commit(len);
    host_send(len);

    // Back-pressure: writes and commits while busy must not disturb the packet.
    for (int i = 0; i < 4; i++) write_byte(8'hC1 + 8'(i), 1'b1);
    commit(len);
    wr_strobe = 1'b1; wr_data = 8'hAA; wr_commit = 1'b1;
    repeat (2) tick();
    wr_strobe = 1'b0; wr_commit = 1'b0;
    check("tx_len_unchanged", 32'(tx_len), 32'(len));
    host_send(len);
    write_byte(8'h11, 1'b1); write_byte(8'h22, 1'b1); write_byte(8'h33, 1'b1);
    commit(len);
    host_send(len);

    // Overflow: only 15 of 20 bytes fit with AW=4.
    for (int i = 0; i < 20; i++) begin
      write_byte(8'(i), i < 15);
      if (i == 14) check("overflow_at_full", 32'(overflow), 32'd0);
      if (i == 15) check("overflow_on_drop", 32'(overflow), 32'd1);
    end
    check("overflow_before_commit", 32'(overflow), 32'd1);
    commit(len);
    check("overflow_cleared", 32'(overflow), 32'd0);
    host_send(len);

    // Empty commit is ignored.
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
    check("empty_commit_req", 32'(tx_req), 32'd0);
    repeat (3) tick();
    check("empty_commit_busy", 32'(busy), 32'd0);

    // Strobe coinciding with commit on the 4th byte.
    for (int i = 1; i <= 3; i++) write_byte(8'h40 + 8'(i), 1'b1);
    wr_strobe = 1'b1; wr_data = 8'h44;
    exp_q.push_back(8'h44);
    stored_n++;
    commit(len);
    host_send(len);

    // Short packet 01..05 (padded to 18 when the pad feature is built).
    for (int i = 1; i <= 5; i++) write_byte(8'(i), 1'b1);
    commit(len);
    host_send(len);

    // Reset after 3 of 8 tx_warns.
    for (int i = 0; i < 8; i++) write_byte(8'hB0 + 8'(i), 1'b1);
    commit(len);
    tx_ack = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tx_warn = 1'b1; tick(); tx_warn = 1'b0; tick();
    end
    rst = 1'b1;
    #1;
    check("mid_rst_tx_req", 32'(tx_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    exp_q.delete();
    len_q.delete();
    tx_ack = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    write_byte(8'h5A, 1'b1); write_byte(8'h5B, 1'b1);
    commit(len);
    host_send(len);

    repeat (3) tick();
    check("exp_bytes_drained", 32'(exp_q.size()), 32'd0);
    check("exp_lens_drained", 32'(len_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_tx_buf.md
Name: udp_tx_buf

Overview:
- Tx client for the PSPEPS Ethernet core. It is the transmit-side counterpart of the Rx client feed (rx_ready/rx_strobe/rx_data).
- A local producer (SPI slave command decoder, status logger) writes bytes into a single-packet buffer and commits the packet. The block then requests transmission and streams the bytes out under PSPEPS tx_req/tx_ack/tx_warn timing.
- One packet in flight; the producer is back-pressured by `busy`.

Parameters:
- AW, 11, buffer address width; capacity 2^AW bytes (at most 2047 sent, since tx_len is 11 bits).
- MIN_LEN, 18, minimum payload length used only when the optional pad feature is enabled.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- wr_strobe  input  1  byte write; ignored while busy=1.
- wr_data  input  8  byte written on wr_strobe.
- wr_commit  input  1  end of packet; ignored while busy=1.
- busy  output  1  high from accepted commit until the transfer closes.
- overflow  output  1  sticky; set when a byte is dropped because the buffer is full; cleared by the next accepted commit.
- tx_req  output  1  transmit request to PSPEPS.
- tx_len  output  11  packet length in bytes; stable while tx_req=1.
- tx_ack  input  1  PSPEPS grant.
- tx_warn  input  1  PSPEPS byte request; host sends exactly tx_len of these.
- tx_data  output  8  byte; valid the cycle after each tx_warn.

Behaviour:
- Reset values: tx_req=0, tx_len=0, tx_data=0, busy=0, overflow=0; write pointer=0; state=IDLE. Reset mid-packet abandons the packet with no partial transmit.
- States: IDLE → FILL → REQ → SEND → CLOSE → IDLE.
- IDLE/FILL:
  - wr_strobe stores wr_data at wptr, then wptr+1; first byte moves to FILL.
  - If wptr = 2^AW−1 already holds data, further bytes are dropped and overflow=1.
  - Length saturates at 2^AW−1, truncated to 11 bits.
- Commit:
  - wr_commit with length 0 is ignored: stays IDLE, no request.
  - Otherwise, at the next edge: latch tx_len=wptr, busy=1, tx_req=1, state REQ, overflow cleared.
  - wr_strobe and wr_commit in the same cycle: the byte is stored first and included in the length.
- REQ: wait for tx_ack=1, then go to SEND. tx_warn seen before tx_ack is a protocol error; it is still serviced the same way as in SEND.
- SEND:
  - On each tx_warn, register tx_data ← mem[rptr] and increment rptr. Read latency is exactly 1 cycle (tx_warn at cycle n, data valid at n+1, host samples via its tx_strobe).
  - On the tx_warn whose rptr = tx_len−1, drop tx_req at the same edge that registers the last byte, and go to CLOSE.
- CLOSE: wait for tx_ack=0, then reset wptr/rptr=0, busy=0, and return to IDLE. A new packet can be filled the cycle after busy falls.
- tx_warn outside REQ/SEND is ignored; tx_data holds its value.
- Memory: single-clock, 2^AW×8 inferred RAM with registered read.

Optional Feature:
- Macro: UDP_TX_BUF_PAD_EN.
- Defined: at commit, if length < MIN_LEN, tx_len = MIN_LEN. In SEND, reads with rptr ≥ stored length return 8'h00.
- Undefined: tx_len equals the stored byte count exactly; no padding logic is built.

Decomposition:
- Shared package/header (ether_tx_defs):
  - state encodings (IDLE=0, FILL=1, REQ=2, SEND=3, CLOSE=4);
  - TX_LEN_W=11;
  - default MIN_LEN.
- One natural sub-module, `tx_buf_ram`: simple dual-port RAM with write port (we, waddr, wdata) and registered read port (re, raddr, rdata). The FSM and pointers stay in udp_tx_buf.

Test Plan:
- Basic packet:
  - Stimulus: write 8 bytes 01..08, commit, PSPEPS emulator grants.
  - Required: tx_req rises 1 cycle after commit with tx_len=8. Host captures 0102030405060708. tx_req falls on the 8th tx_warn; busy falls after tx_ack drops.
- Back-pressure:
  - Stimulus: assert wr_strobe with 8'hAA and wr_commit while busy=1.
  - Required: no change to the in-flight packet. The next packet, 3 bytes 11 22 33, is sent with tx_len=3.
- Overflow (AW=4):
  - Stimulus: write 20 bytes 00..13, commit.
  - Required: overflow=1 before commit; tx_len=15; data 00..0E. overflow clears at commit.
- Edge cases:
  - Stimulus: commit with no bytes; separately, a strobe coinciding with commit on the 4th byte.
  - Required: no tx_req for the empty commit; tx_len=4 for the second case.
- Reset mid-SEND:
  - Stimulus: assert rst after 3 of 8 tx_warns.
  - Required: tx_req=0, busy=0, tx_data=0 immediately (asynchronous). A following 2-byte packet sends correctly from address 0.
- UDP_TX_BUF_PAD_EN defined:
  - Stimulus: 5-byte packet 01..05.
  - Required: tx_len=18; host receives 01..05 followed by 13 bytes of 00.
